// File: rtl/multicycle_control_fsm.sv
// Main control FSM for a multicycle RISC-V style datapath.
// Outputs decode combinationally from the state register and the current instruction.
module multicycle_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUctrl,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ImmSrc,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC+4 when memory completes
  // DECODE   | register read, branch target precomputed into ALUOut
  // MEMADR   | effective address rs1 + imm
  // MEMREAD  | load access, waits on mem_ready
  // MEMWB    | load data written to rd
  // MEMWRITE | store access, waits on mem_ready
  // EXECR    | register-register ALU op
  // EXECI    | register-immediate ALU op
  // ALUWB    | ALUOut written to rd
  // JAL      | PC <= target, ALU forms OldPC+4 for the link
  // BRANCH   | compare rs1/rs2, PC <= target when taken
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7b5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_decode = 3'b001;
      OP_BRANCH: imm_decode = 3'b010;
      OP_JAL:    imm_decode = 3'b011;
      default:   imm_decode = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] alu_decode(input logic [6:0] op, input logic [2:0] f3,
                                            input logic b30);
    case (f3)
      3'b000:  alu_decode = (op == OP_RTYPE && b30) ? ALU_SUB : ALU_ADD;
      3'b100:  alu_decode = ALU_XOR;
      3'b110:  alu_decode = ALU_OR;
      3'b111:  alu_decode = ALU_AND;
      3'b010:  alu_decode = ALU_SLT;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUctrl    = ALU_ADD;
    ResultSrc  = 2'b00;
    ImmSrc     = imm_decode(opcode);
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUctrl = alu_decode(opcode, funct3, funct7b5);
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUctrl = alu_decode(opcode, funct3, funct7b5);
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUctrl    = ALU_SUB;
        instr_done = 1'b1;
        PCWrite    = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences every strobe immediately, not just at the next edge.
    if (!rst_n) begin
      mem_req    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUctrl    = ALU_ADD;
      ResultSrc  = 2'b00;
      ImmSrc     = 3'b000;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Ports SHALL be, in this order:
  clk  in  1  system clock
  rst_n  in  1  asynchronous active-low reset
  instr  in  32  instruction register contents, valid from DECODE onward
  zero  in  1  ALU zero flag, 1 when operands are equal
  mem_ready  in  1  memory completes the current access this cycle
  mem_req  out  1  memory access request
  AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
  MemWrite  out  1  memory write strobe
  IRWrite  out  1  instruction register load
  PCWrite  out  1  PC load
  RegWrite  out  1  register file write
  ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
  ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
  ALUctrl  out  3  ALU op: 000 = add, 001 = sub, 010 = xor, 011 = and, 100 = or, 101 = slt
  ResultSrc  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALU result direct
  ImmSrc  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J
  instr_done  out  1  one-cycle pulse when an instruction retires
  illegal  out  1  one-cycle pulse on an unsupported opcode
  state  out  4  current state encoding, for debug

Function
REQ-003 States SHALL be: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH; the state register SHALL be the only sequential element.
REQ-004 Outputs SHALL be combinational from state, instr, zero and mem_ready; any output not listed for a state SHALL be 0, and ALUctrl/ALUSrcA/ALUSrcB/ResultSrc SHALL default to 000/00/00/00.
REQ-005 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=add, ResultSrc=10.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1.
  - Next state is DECODE when mem_ready=1; otherwise remain in FETCH.
REQ-006 DECODE: ALUSrcA=01, ALUSrcB=01, ALUctrl=add (precomputes branch target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - any other opcode -> FETCH with illegal=1 for that cycle
REQ-007 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUctrl=add; next state MEMREAD if opcode is 0000011, else MEMWRITE.
REQ-008 MEMREAD: mem_req=1, AdrSrc=1; remain until mem_ready=1, then go to MEMWB.
REQ-009 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1; next state FETCH.
REQ-010 MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 held for every cycle of the wait; instr_done=1 and next state FETCH on mem_ready=1.
REQ-011 EXECR: ALUSrcA=10, ALUSrcB=00; next state ALUWB.
REQ-012 EXECI: ALUSrcA=10, ALUSrcB=01; next state ALUWB.
REQ-013 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1; next state FETCH.
REQ-014 JAL: ALUSrcA=01, ALUSrcB=10, ALUctrl=add, ResultSrc=00, PCWrite=1; next state ALUWB (writes OldPC+4 to rd).
REQ-015 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUctrl=sub, ResultSrc=00, instr_done=1; next state FETCH.
  - PCWrite=1 iff (funct3=000 and zero=1) or (funct3=001 and zero=0).
  - Any other funct3 SHALL not branch.
REQ-016 ALU decode in EXECR/EXECI, with funct3 = instr[14:12]:
  - funct3 000 -> sub when opcode is 0110011 and instr[30]=1, else add
  - 100 -> xor; 110 -> or; 111 -> and; 010 -> slt
  - any other funct3 -> add
REQ-017 ImmSrc SHALL decode from opcode in every state: 0100011 -> 001, 1100011 -> 010, 1101111 -> 011, all others -> 000.
REQ-018 mem_ready SHALL be ignored in every state except FETCH, MEMREAD and MEMWRITE; stalls of any length SHALL hold all outputs stable.

Reset
REQ-019 rst_n low SHALL force the state to FETCH immediately, independent of clk.
REQ-020 While rst_n is low, all outputs SHALL be 0 and state SHALL read FETCH.
REQ-021 The first rising clk edge after rst_n rises SHALL be evaluated as FETCH.
REQ-022 Reset asserted mid-instruction SHALL abandon the instruction with no further PCWrite, RegWrite or MemWrite.

Verification
REQ-023 add x3,x1,x2 (instr 0x002081B3), mem_ready=1 in FETCH -> states FETCH, DECODE, EXECR, ALUWB; ALUctrl=000 in EXECR; RegWrite=1 and instr_done=1 in cycle 4.
REQ-024 lw (0x0000A103) with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with mem_req=1, AdrSrc=1; then MEMWB with ResultSrc=01, RegWrite=1.
REQ-025 bne (funct3=001) with zero=1 -> PCWrite=0 in BRANCH; repeat with zero=0 -> PCWrite=1, ALUctrl=001.
REQ-026 Opcode 0000000 -> DECODE pulses illegal=1 and returns to FETCH; no RegWrite or MemWrite at any point.
REQ-027 sw with rst_n dropped during MEMWRITE -> all outputs 0 asynchronously; after release state=FETCH and MemWrite stays 0.
